// File: rtl/sha256_msg_sequencer.sv
// Packs a 16-bit big-endian byte stream into 512-bit SHA-256 blocks, applies
// message padding and sequences init/next pulses to the core, capturing the digest.
module sha256_msg_sequencer #(
    parameter int LEN_W = 64
) (
    input  logic         mclk,
    input  logic         puc_rst,
    input  logic         start,
    input  logic         mode_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  in_data,
    input  logic         in_last,
    input  logic [1:0]   in_bytes,
    output logic         core_init,
    output logic         core_next,
    output logic         core_mode,
    output logic [511:0] core_block,
    input  logic         core_ready,
    input  logic         core_dvalid,
    input  logic [255:0] core_digest,
    output logic         busy,
    output logic [255:0] digest,
    output logic         digest_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PAD,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [6:0]       byte_ptr;
    logic [LEN_W-1:0] bit_len;
    logic             first;
    logic             is_final;
    logic             pad_pend;
    logic             flag80_pend;
    logic [511:0]     block;

    logic [1:0]       nbytes;
    logic [9:0]       lo_idx0;
    logic [9:0]       lo_idx1;
    logic [63:0]      len64;

    logic             do_start;
    logic             accept;
    logic             fill_full;
    logic             do_issue;
    logic             do_capture;
    logic             do_padblk;
    logic             do_refill;

    assign core_block = block;

    // Bit positions of the byte at byte_ptr and the one after it (byte 0 is the MSB).
    always_comb begin
        lo_idx0 = 10'd504 - {byte_ptr, 3'b000};
        lo_idx1 = 10'd496 - {byte_ptr, 3'b000};
        len64   = '0;
        len64[LEN_W-1:0] = bit_len;
        if (!in_last)
            nbytes = 2'd2;
        else if (in_bytes == 2'd3)
            nbytes = 2'd2;
        else
            nbytes = in_bytes;
    end

    always_ff @(posedge mclk) begin
        if (puc_rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        do_start   = 1'b0;
        accept     = 1'b0;
        fill_full  = 1'b0;
        do_issue   = 1'b0;
        do_capture = 1'b0;
        do_padblk  = 1'b0;
        do_refill  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                busy = 1'b0;
                if (start) begin
                    do_start  = 1'b1;
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    if (in_last) begin
                        state_nxt = S_PAD;
                    end else if (byte_ptr == 7'd62) begin
                        fill_full = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_PAD: begin
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (core_ready) begin
                    do_issue  = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // The pulse is still high in the first WAIT cycle, when core_ready is stale.
                if (core_ready && !(core_init || core_next)) begin
                    if (is_final) begin
                        if (core_dvalid) begin
                            do_capture = 1'b1;
                            state_nxt  = S_DONE;
                        end
                    end else if (pad_pend) begin
                        do_padblk = 1'b1;
                        state_nxt = S_ISSUE;
                    end else begin
                        do_refill = 1'b1;
                        state_nxt = S_FILL;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            core_init    <= 1'b0;
            core_next    <= 1'b0;
            core_mode    <= 1'b0;
            byte_ptr     <= '0;
            bit_len      <= '0;
            first        <= 1'b1;
            is_final     <= 1'b0;
            pad_pend     <= 1'b0;
            flag80_pend  <= 1'b0;
            block        <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
        end else begin
            core_init <= 1'b0;
            core_next <= 1'b0;

            if (do_start) begin
                core_mode    <= mode_in;
                bit_len      <= '0;
                first        <= 1'b1;
                block        <= '0;
                byte_ptr     <= '0;
                digest_valid <= 1'b0;
                is_final     <= 1'b0;
                pad_pend     <= 1'b0;
                flag80_pend  <= 1'b0;
            end

            if (accept) begin
                if (nbytes != 2'd0)
                    block[lo_idx0 +: 8] <= in_data[15:8];
                if (nbytes == 2'd2)
                    block[lo_idx1 +: 8] <= in_data[7:0];
                byte_ptr <= byte_ptr + 7'(nbytes);
                bit_len  <= bit_len + LEN_W'({nbytes, 3'b000});
            end

            if (fill_full) begin
                is_final <= 1'b0;
                pad_pend <= 1'b0;
            end

            // A full last block defers its 0x80 marker to byte 0 of the extra block.
            if (state == S_PAD) begin
                if (!byte_ptr[6])
                    block[lo_idx0 +: 8] <= 8'h80;
                else
                    flag80_pend <= 1'b1;
                if (byte_ptr <= 7'd55) begin
                    block[63:0] <= len64;
                    is_final    <= 1'b1;
                end else begin
                    pad_pend <= 1'b1;
                    is_final <= 1'b0;
                end
            end

            if (do_issue) begin
                core_init <= first;
                core_next <= !first;
                first     <= 1'b0;
            end

            if (do_capture) begin
                digest       <= core_digest;
                digest_valid <= 1'b1;
            end

            if (do_padblk) begin
                block       <= {(flag80_pend ? 8'h80 : 8'h00), 440'd0, len64};
                is_final    <= 1'b1;
                pad_pend    <= 1'b0;
                flag80_pend <= 1'b0;
            end

            if (do_refill) begin
                block    <= '0;
                byte_ptr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Directed bench for sha256_msg_sequencer with a behavioural SHA-256 core model
// checked against known FIPS 180-4 digests and an independent padding model.
module tb_sha256_msg_sequencer;

    logic         mclk;
    logic         puc_rst;
    logic         start;
    logic         mode_in;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_data;
    logic         in_last;
    logic [1:0]   in_bytes;
    logic         core_init;
    logic         core_next;
    logic         core_mode;
    logic [511:0] core_block;
    logic         core_ready;
    logic         core_dvalid;
    logic [255:0] core_digest;
    logic         busy;
    logic [255:0] digest;
    logic         digest_valid;

    int tests = 0;
    int failures = 0;
    int stall_cnt = 0;
    logic [7:0] msg [0:127];

    localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_56 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    sha256_msg_sequencer #(.LEN_W(64)) dut (
        .mclk(mclk), .puc_rst(puc_rst), .start(start), .mode_in(mode_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_bytes(in_bytes),
        .core_init(core_init), .core_next(core_next), .core_mode(core_mode),
        .core_block(core_block), .core_ready(core_ready), .core_dvalid(core_dvalid),
        .core_digest(core_digest), .busy(busy), .digest(digest),
        .digest_valid(digest_valid)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_iv(input logic mode);
        if (mode)
            return 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
        return 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++)
            w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    // Core model: ready drops the cycle after a pulse, digest valid after a fixed latency.
    logic [255:0] h_cur = '0;
    int           busy_cnt = 0;
    logic         dv = 1'b0;
    logic         ready_hold = 1'b0;
    int           n_init = 0;
    int           n_next = 0;
    int           n_blocks = 0;
    logic [511:0] blk_log [0:15];

    assign core_ready  = (busy_cnt == 0) && !ready_hold;
    assign core_dvalid = dv;
    assign core_digest = h_cur;

    always @(posedge mclk) begin
        if (core_init || core_next) begin
            h_cur <= sha_compress(core_init ? sha_iv(core_mode) : h_cur, core_block);
            blk_log[n_blocks % 16] <= core_block;
            n_blocks <= n_blocks + 1;
            if (core_init)
                n_init <= n_init + 1;
            else
                n_next <= n_next + 1;
            busy_cnt <= 6;
            dv <= 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1)
                dv <= 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic loadString(input string s);
        for (int i = 0; i < s.len(); i++)
            msg[i] = s[i];
    endtask

    task automatic loadPattern(input int len, input int mul, input int add);
        for (int i = 0; i < len; i++)
            msg[i] = 8'((i * mul + add) & 255);
    endtask

    // Independent padding model: message, 0x80, zeros, 64-bit bit length.
    function automatic logic [511:0] expectedBlock(input int len, input int b);
        logic [511:0] r;
        logic [63:0]  bits;
        logic [7:0]   v;
        int total;
        int idx;
        total = ((len + 8) / 64 + 1) * 64;
        bits  = 64'(len) * 64'd8;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            idx = b * 64 + i;
            if (idx < len)
                v = msg[idx];
            else if (idx == len)
                v = 8'h80;
            else if (idx >= total - 8)
                v = bits[8*(total - 1 - idx) +: 8];
            else
                v = 8'h00;
            r[8*(63 - i) +: 8] = v;
        end
        return r;
    endfunction

    task automatic applyStimulus(input int len, input logic mode);
        int   nwords;
        int   w;
        int   guard;
        logic acc;
        @(posedge mclk); #1;
        start   = 1'b1;
        mode_in = mode;
        @(posedge mclk); #1;
        start     = 1'b0;
        nwords    = (len == 0) ? 1 : (len + 1) / 2;
        stall_cnt = 0;
        w = 0;
        guard = 0;
        while (w < nwords && guard < 3000) begin
            in_valid = 1'b1;
            in_data  = {msg[2*w], (2*w + 1 < len) ? msg[2*w + 1] : 8'h00};
            in_last  = (w == nwords - 1);
            in_bytes = (w == nwords - 1) ? 2'(len - 2*w) : 2'd2;
            @(negedge mclk);
            acc = in_ready;
            if (!acc)
                stall_cnt++;
            @(posedge mclk); #1;
            if (acc)
                w++;
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("send_words", 512'(w), 512'(nwords));
    endtask

    task automatic waitDigest(input string tag);
        int g;
        g = 0;
        while (!digest_valid && g < 2000) begin
            @(posedge mclk); #1;
            g++;
        end
        checkOutput({tag, "_done"}, 512'(digest_valid), 512'(1));
    endtask

    task automatic checkBlocks(input string tag, input int len, input int base);
        int nb;
        nb = (len + 8) / 64 + 1;
        checkOutput({tag, "_nblocks"}, 512'(n_blocks - base), 512'(nb));
        for (int b = 0; b < nb; b++)
            checkOutput($sformatf("%s_blk%0d", tag, b), blk_log[(base + b) % 16], expectedBlock(len, b));
    endtask

    initial begin
        int bb;
        int bi;
        int bn;
        int g;
        puc_rst  = 1'b1;
        start    = 1'b0;
        mode_in  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_bytes = '0;
        repeat (3) @(posedge mclk);
        #1;
        puc_rst = 1'b0;
        checkOutput("rst_busy", 512'(busy), 512'(0));
        checkOutput("rst_dvalid", 512'(digest_valid), 512'(0));
        checkOutput("rst_in_ready", 512'(in_ready), 512'(0));
        checkOutput("rst_core_init", 512'(core_init), 512'(0));
        checkOutput("rst_core_next", 512'(core_next), 512'(0));
        checkOutput("rst_digest", 512'(digest), 512'(0));

        $display("[TB] abc");
        loadString("abc");
        bb = n_blocks; bi = n_init; bn = n_next;
        applyStimulus(3, 1'b1);
        checkOutput("abc_busy", 512'(busy), 512'(1));
        waitDigest("abc");
        checkOutput("abc_digest", 512'(digest), 512'(DIG_ABC));
        checkOutput("abc_inits", 512'(n_init - bi), 512'(1));
        checkOutput("abc_nexts", 512'(n_next - bn), 512'(0));
        checkOutput("abc_mode", 512'(core_mode), 512'(1));
        checkBlocks("abc", 3, bb);
        repeat (5) @(posedge mclk);
        #1;
        checkOutput("abc_dvalid_hold", 512'(digest_valid), 512'(1));
        checkOutput("abc_idle_busy", 512'(busy), 512'(0));

        $display("[TB] empty");
        bb = n_blocks;
        applyStimulus(0, 1'b1);
        waitDigest("empty");
        checkOutput("empty_digest", 512'(digest), 512'(DIG_EMPTY));
        checkOutput("empty_byte0", 512'(blk_log[bb % 16][511:504]), 512'(8'h80));
        checkBlocks("empty", 0, bb);

        $display("[TB] 55 bytes");
        loadPattern(55, 7, 3);
        bb = n_blocks;
        applyStimulus(55, 1'b1);
        waitDigest("b55");
        checkOutput("b55_byte55", 512'(blk_log[bb % 16][511 - 55*8 -: 8]), 512'(8'h80));
        checkOutput("b55_len", 512'(blk_log[bb % 16][63:0]), 512'(64'h1B8));
        checkBlocks("b55", 55, bb);
        checkOutput("b55_digest", 512'(digest), 512'(h_cur));

        $display("[TB] 56 bytes");
        loadString("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        bb = n_blocks; bi = n_init; bn = n_next;
        applyStimulus(56, 1'b1);
        waitDigest("b56");
        checkOutput("b56_digest", 512'(digest), 512'(DIG_56));
        checkOutput("b56_inits", 512'(n_init - bi), 512'(1));
        checkOutput("b56_nexts", 512'(n_next - bn), 512'(1));
        checkBlocks("b56", 56, bb);

        $display("[TB] 64 bytes, core_ready held low");
        loadPattern(64, 1, 0);
        ready_hold = 1'b1;
        bb = n_blocks; bi = n_init;
        applyStimulus(64, 1'b1);
        repeat (20) @(posedge mclk);
        #1;
        checkOutput("b64_hold_no_pulse", 512'(n_init - bi), 512'(0));
        checkOutput("b64_hold_busy", 512'(busy), 512'(1));
        ready_hold = 1'b0;
        waitDigest("b64");
        checkOutput("b64_blk1_byte0", 512'(blk_log[(bb + 1) % 16][511:504]), 512'(8'h80));
        checkOutput("b64_blk1_len", 512'(blk_log[(bb + 1) % 16][63:0]), 512'(64'h200));
        checkBlocks("b64", 64, bb);
        checkOutput("b64_digest", 512'(digest), 512'(h_cur));

        $display("[TB] 100 bytes, in_valid held across block boundary");
        loadPattern(100, 3, 5);
        bb = n_blocks;
        applyStimulus(100, 1'b1);
        waitDigest("b100");
        checkOutput("b100_stalled", 512'(stall_cnt > 0), 512'(1));
        checkBlocks("b100", 100, bb);
        checkOutput("b100_digest", 512'(digest), 512'(h_cur));

        $display("[TB] reset in WAIT");
        loadString("abc");
        applyStimulus(3, 1'b1);
        g = 0;
        while (!core_init && g < 100) begin
            @(posedge mclk); #1;
            g++;
        end
        checkOutput("rstw_saw_init", 512'(core_init), 512'(1));
        puc_rst = 1'b1;
        @(posedge mclk); #1;
        puc_rst = 1'b0;
        checkOutput("rstw_busy", 512'(busy), 512'(0));
        checkOutput("rstw_dvalid", 512'(digest_valid), 512'(0));
        checkOutput("rstw_core_init", 512'(core_init), 512'(0));
        checkOutput("rstw_in_ready", 512'(in_ready), 512'(0));
        bi = n_init;
        applyStimulus(3, 1'b1);
        waitDigest("rstw_abc");
        checkOutput("rstw_abc_digest", 512'(digest), 512'(DIG_ABC));
        checkOutput("rstw_abc_inits", 512'(n_init - bi), 512'(1));

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
